sha_mem_responder: RTL and testbench

SHA_MEM_RESPONDER -- requirements
Module: sha_mem_responder

---
 rtl/sha_mem_pkg.sv | 22 ++
 rtl/sha_mem_responder_if.sv | 44 ++++
 rtl/sha_word_ram.sv | 49 ++++
 rtl/sha_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_sha_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_mem_pkg.sv
// Shared types and constants for the SHA memory responder: FSM state encoding,
// default address map and the address range helper used by the RAM and its owner.
package sha_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_KICK = 3'd2,
        ST_WAIT = 3'd3,
        ST_DUMP = 3'd4
    } state_e;

    localparam logic [15:0] DEF_MESSAGE_ADDR = 16'd0;
    localparam logic [15:0] DEF_OUTPUT_ADDR  = 16'd32;
    localparam int          HASH_WORDS       = 8;

    // True when a 16-bit word address falls inside a RAM of the given depth.
    function automatic logic addr_in_range(input logic [15:0] addr, input int depth);
        return ({16'd0, addr} < $unsigned(depth));
    endfunction

endpackage

// File: rtl/sha_mem_responder_if.sv
// Host and core facing signals of the SHA memory responder, bundled with one
// modport for the responder (slave) and one for whatever drives it (master).
interface sha_mem_responder_if;

    // Valid/ready: a word moves on a rising clk edge where valid and ready are
    // both high; the side holding valid keeps its data unchanged until then.
    logic        host_go;
    logic        busy;
    logic        error;

    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;

    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    // Core side: core_start is a one-cycle pulse, the memory port is sampled
    // every clk edge while the responder is waiting on the core.
    logic        core_start;
    logic        core_done;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  host_go, in_valid, in_data, out_ready,
        input  core_done, mem_we, mem_addr, mem_write_data,
        output busy, error, in_ready, out_valid, out_data,
        output core_start, message_addr, output_addr, mem_read_data
    );

    modport master (
        output host_go, in_valid, in_data, out_ready,
        output core_done, mem_we, mem_addr, mem_write_data,
        input  busy, error, in_ready, out_valid, out_data,
        input  core_start, message_addr, output_addr, mem_read_data
    );

endinterface

// File: rtl/sha_word_ram.sv
// Single-port DEPTH x 32 word RAM with a registered, write-first read port.
// Out-of-range accesses never touch the array and read back as zero.
module sha_word_ram
    import sha_mem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_en,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_rdata;
    logic          w_hit;
    logic [AW-1:0] w_idx;

    assign w_hit   = addr_in_range(i_addr, DEPTH);
    assign w_idx   = i_addr[AW-1:0];
    assign o_rdata = r_rdata;

    // The array carries no reset so its contents survive a mid-job reset.
    always_ff @(posedge clk) begin
        if (i_en && i_we && w_hit) begin
            r_mem[w_idx] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= 32'h0;
        end else if (i_en) begin
            if (!w_hit) begin
                r_rdata <= 32'h0;
            end else if (i_we) begin
                r_rdata <= i_wdata;
            end else begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

endmodule

// File: rtl/sha_mem_responder.sv
// Loads a message from the host into a shared RAM, hands the RAM to a hash core
// until it reports done (or a watchdog expires), then streams the hash back.
module sha_mem_responder
    import sha_mem_pkg::*;
#(
    parameter int          NUM_OF_WORDS = 20,
    parameter int          DEPTH        = 64,
    parameter logic [15:0] MESSAGE_ADDR = DEF_MESSAGE_ADDR,
    parameter logic [15:0] OUTPUT_ADDR  = DEF_OUTPUT_ADDR,
    parameter int          TIMEOUT      = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sha_mem_responder_if.slave   bus,
    output state_e               o_state
);

    localparam logic [15:0] LAST_WORD = 16'(NUM_OF_WORDS - 1);
    localparam logic [15:0] HASH_N    = 16'(HASH_WORDS);
    // KICK is the first counted cycle, so WAIT gives up TIMEOUT-1 cycles later.
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT - 2);

    state_e      r_state;
    logic [15:0] r_count;
    logic [31:0] r_wdog;
    logic        r_pend;
    logic        r_core_start;
    logic        r_error;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_core_owned;
    logic [31:0] r_mem_hold;

    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_fetch;
    logic        w_core_bad;
    logic        w_ram_en;
    logic        w_ram_we;
    logic [15:0] w_ram_addr;
    logic [31:0] w_ram_wdata;
    logic [31:0] w_ram_rdata;

    sha_word_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // RAM port ownership follows the state: host writes, core access, dump reads.
    always_comb begin
        w_in_fire   = (r_state == ST_LOAD) && bus.in_valid;
        w_out_fire  = r_out_valid && bus.out_ready;
        w_fetch     = (r_state == ST_DUMP) && !r_out_valid && !r_pend && (r_count < HASH_N);
        w_core_bad  = (r_state == ST_WAIT) && !addr_in_range(bus.mem_addr, DEPTH);
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = 16'h0;
        w_ram_wdata = 32'h0;
        case (r_state)
            ST_LOAD: begin
                w_ram_en    = w_in_fire;
                w_ram_we    = 1'b1;
                w_ram_addr  = MESSAGE_ADDR + r_count;
                w_ram_wdata = bus.in_data;
            end
            ST_WAIT: begin
                w_ram_en    = 1'b1;
                w_ram_we    = bus.mem_we;
                w_ram_addr  = bus.mem_addr;
                w_ram_wdata = bus.mem_write_data;
            end
            ST_DUMP: begin
                w_ram_en    = w_fetch;
                w_ram_addr  = OUTPUT_ADDR + r_count;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_count      <= 16'h0;
            r_wdog       <= 32'h0;
            r_pend       <= 1'b0;
            r_core_start <= 1'b0;
            r_error      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 32'h0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.host_go) begin
                        r_state <= ST_LOAD;
                        r_count <= 16'h0;
                        r_error <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_in_fire) begin
                        if (r_count == LAST_WORD) begin
                            r_state      <= ST_KICK;
                            r_count      <= 16'h0;
                            r_core_start <= 1'b1;
                        end else begin
                            r_count <= r_count + 16'd1;
                        end
                    end
                end
                ST_KICK: begin
                    r_wdog  <= 32'h0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_core_bad) begin
                        r_error <= 1'b1;
                    end
                    if (bus.core_done) begin
                        r_state <= ST_DUMP;
                        r_count <= 16'h0;
                        r_pend  <= 1'b0;
                    end else if (r_wdog == WDOG_LAST) begin
                        r_error <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 32'd1;
                    end
                end
                ST_DUMP: begin
                    // Fetch, capture, then hold the word until the host takes it.
                    if (w_fetch) begin
                        r_count <= r_count + 16'd1;
                        r_pend  <= 1'b1;
                    end
                    if (r_pend) begin
                        r_out_data  <= w_ram_rdata;
                        r_out_valid <= 1'b1;
                        r_pend      <= 1'b0;
                    end
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        if (r_count == HASH_N) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The core sees RAM read data only for its own accesses; dump reads are hidden.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_core_owned <= 1'b0;
            r_mem_hold   <= 32'h0;
        end else begin
            r_core_owned <= (r_state == ST_WAIT);
            if (r_core_owned) begin
                r_mem_hold <= w_ram_rdata;
            end
        end
    end

    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.error         = r_error;
    assign bus.in_ready      = (r_state == ST_LOAD);
    assign bus.out_valid     = r_out_valid;
    assign bus.out_data      = r_out_data;
    assign bus.core_start    = r_core_start;
    assign bus.message_addr  = MESSAGE_ADDR;
    assign bus.output_addr   = OUTPUT_ADDR;
    assign bus.mem_read_data = r_core_owned ? w_ram_rdata : r_mem_hold;
    assign o_state           = r_state;

endmodule

// File: tb/tb_sha_mem_responder.sv
// Self-checking bench for sha_mem_responder: full jobs with a core model,
// core-port vector table, dump back-pressure, watchdog expiry and mid-load reset.
module tb_sha_mem_responder;
  import sha_mem_pkg::*;

  localparam int NW    = 20;
  localparam int DEPTH = 64;
  localparam int TO    = 4096;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wd;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  int n_start = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model_ram [DEPTH];
  vec_t vt [15];
  state_e dbg_state;

  sha_mem_responder_if bus ();

  sha_mem_responder #(
    .NUM_OF_WORDS (NW),
    .DEPTH        (DEPTH),
    .MESSAGE_ADDR (16'd0),
    .OUTPUT_ADDR  (16'd32),
    .TIMEOUT      (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .o_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.core_start === 1'b1) n_start++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1);
  end

  // driver tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job();
    bus.host_go = 1'b1;
    tick();
    bus.host_go = 1'b0;
  endtask

  task automatic load_words(input logic [31:0] base, input bit gaps, input int stop_at,
                            output int nxfer);
    int k = 0;
    int guard = 0;
    while (k < NW && guard < 400) begin
      bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_data  = base + 32'(k);
      if (k == stop_at && bus.in_ready && bus.in_valid) begin
        #3;
        reset_n = 1'b0;
        #1;
        break;
      end
      if (bus.in_ready && bus.in_valid) begin
        model_ram[k] = base + 32'(k);
        k++;
      end
      tick();
      guard++;
    end
    bus.in_valid = 1'b0;
    nxfer = k;
  endtask

  task automatic after_load();
    chk("kick_core_start", 32'(bus.core_start), 32'd1);
    chk("kick_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("wait_core_start_low", 32'(bus.core_start), 32'd0);
    chk("wait_state", 32'(dbg_state), 32'(ST_WAIT));
  endtask

  task automatic core_op(input logic we, input logic [15:0] addr, input logic [31:0] wd);
    bus.mem_we         = we;
    bus.mem_addr       = addr;
    bus.mem_write_data = wd;
    if (we && addr < 16'(DEPTH)) model_ram[int'(addr)] = wd;
    tick();
    bus.mem_we = 1'b0;
  endtask

  task automatic finish_core();
    bus.core_done = 1'b1;
    for (int i = 32; i < 40; i++) exp_q.push_back(model_ram[i]);
    tick();
    bus.core_done = 1'b0;
  endtask

  // scoreboard side: pop one expected word per accepted output transfer
  task automatic dump(input bit rnd);
    bit pat [4];
    bit stalled;
    logic [31:0] held;
    logic [31:0] expv;
    int got;
    int g;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    stalled = 1'b0;
    held = 32'h0;
    got = 0;
    g = 0;
    while (got < 8 && g < 300) begin
      if (stalled) begin
        chk("dump_valid_held", 32'(bus.out_valid), 32'd1);
        chk("dump_data_stable", bus.out_data, held);
      end
      stalled = 1'b0;
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : pat[g % 4];
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (exp_q.size() > 0) expv = exp_q.pop_front();
          else expv = 32'hBAD0_BAD0;
          chk("dump_word", bus.out_data, expv);
          got++;
        end else begin
          stalled = 1'b1;
          held = bus.out_data;
        end
      end
      tick();
      g++;
    end
    bus.out_ready = 1'b0;
    chk("dump_count", 32'(got), 32'd8);
  endtask

  task automatic idle_after_dump(input logic [31:0] exp_mrd);
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_out_valid", 32'(bus.out_valid), 32'd0);
    chk("end_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("end_mem_rd_hold", bus.mem_read_data, exp_mrd);
    chk("end_sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int m;

    bus.host_go = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 32'h0;
    bus.out_ready = 1'b0;
    bus.core_done = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_addr = 16'h0;
    bus.mem_write_data = 32'h0;
    for (int i = 0; i < DEPTH; i++) model_ram[i] = 32'h0;

    vt[0] = '{1'b0, 16'd5, 32'h0, 1'b1, 32'h6, 1'b0};
    for (int i = 0; i < 8; i++)
      vt[1 + i] = '{1'b1, 16'(32 + i), 32'hA5A5_0000 + 32'(i), 1'b0, 32'h0, 1'b0};
    vt[9]  = '{1'b0, 16'd32, 32'h0, 1'b1, 32'hA5A5_0000, 1'b0};
    vt[10] = '{1'b0, 16'd39, 32'h0, 1'b1, 32'hA5A5_0007, 1'b0};
    vt[11] = '{1'b1, 16'd40, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0};
    vt[12] = '{1'b0, 16'd40, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vt[13] = '{1'b0, 16'd70, 32'h0, 1'b1, 32'h0, 1'b1};
    vt[14] = '{1'b0, 16'd5, 32'h0, 1'b1, 32'h6, 1'b1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_mem_rd", bus.mem_read_data, 32'h0);
    chk("rst_core_start", 32'(bus.core_start), 32'd0);
    chk("msg_addr", 32'(bus.message_addr), 32'd0);
    chk("out_addr", 32'(bus.output_addr), 32'd32);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // job 1: ordered load, vector table on the core port, patterned back-pressure
    start_job();
    chk("go_busy", 32'(bus.busy), 32'd1);
    chk("go_in_ready", 32'(bus.in_ready), 32'd1);
    load_words(32'h1, 1'b0, -1, n);
    chk("load_count", 32'(n), 32'(NW));
    after_load();
    chk("start_pulses_1", 32'(n_start), 32'd1);
    for (int i = 0; i < NW; i++) begin
      core_op(1'b0, 16'(i), 32'h0);
      chk("msg_ram", bus.mem_read_data, 32'(i + 1));
    end
    for (int i = 0; i < 15; i++) begin
      core_op(vt[i].we, vt[i].addr, vt[i].wd);
      if (vt[i].chk_rd) chk("core_rd", bus.mem_read_data, vt[i].exp_rd);
      chk("core_err", 32'(bus.error), 32'(vt[i].exp_err));
    end
    finish_core();
    dump(1'b0);
    idle_after_dump(32'h6);

    // job 2: core never finishes, watchdog must fire
    start_job();
    chk("go_clears_err_1", 32'(bus.error), 32'd0);
    load_words($urandom, 1'b1, -1, n);
    chk("load_count_2", 32'(n), 32'(NW));
    chk("kick_core_start_2", 32'(bus.core_start), 32'd1);
    m = 0;
    while (bus.busy && m < TO + 100) begin
      tick();
      m++;
    end
    chk("timeout_cycles", 32'(m), 32'(TO));
    chk("timeout_error", 32'(bus.error), 32'd1);
    chk("timeout_state", 32'(dbg_state), 32'(ST_IDLE));

    // job 3: reset lands on the 10th transfer
    start_job();
    chk("go_clears_err_2", 32'(bus.error), 32'd0);
    load_words(32'h5000, 1'b0, 9, n);
    chk("reset_at_xfer", 32'(n), 32'd9);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_data", bus.out_data, 32'h0);
    chk("mid_rst_mem_rd", bus.mem_read_data, 32'h0);
    chk("mid_rst_core_start", 32'(bus.core_start), 32'd0);
    chk("mid_rst_error", 32'(bus.error), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // job 4: core port write in IDLE must be dropped; RAM survives the reset
    bus.mem_we = 1'b1;
    bus.mem_addr = 16'd36;
    bus.mem_write_data = 32'hFFFF_FFFF;
    tick();
    bus.mem_we = 1'b0;
    start_job();
    load_words(32'h100, 1'b1, -1, n);
    chk("load_count_4", 32'(n), 32'(NW));
    after_load();
    chk("start_pulses_3", 32'(n_start), 32'd3);
    core_op(1'b0, 16'd19, 32'h0);
    chk("j4_rd19", bus.mem_read_data, 32'h113);
    for (int i = 0; i < 4; i++) core_op(1'b1, 16'(32 + i), 32'hC0DE_0000 + 32'(i));
    core_op(1'b0, 16'd9, 32'h0);
    chk("j4_rd9", bus.mem_read_data, 32'h109);
    chk("j4_err", 32'(bus.error), 32'd0);
    finish_core();
    dump(1'b1);
    idle_after_dump(32'h109);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
